// File: rtl/pfu_scaler.sv
// pfu_scaler: complex gain scaler between the IFFT and the DAC.
// It applies a fixed-point gain, rounds half-up and saturates symmetrically.
// Gain changes take effect only at symbol starts.
// It also flags the last sample of each symbol and counts clipped outputs.
module pfu_scaler #(
  parameter int unsigned DI_W         = 12,
  parameter int unsigned DO_W         = 12,
  parameter int unsigned GAIN_W       = 8,
  parameter int unsigned GAIN_FRAC    = 3,
  parameter int unsigned SYM_LEN      = 512,
  parameter int unsigned DEFAULT_GAIN = 181
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DI_W-1:0]   di_re,
  input  logic [DI_W-1:0]   di_im,
  input  logic              di_vld,
  input  logic [GAIN_W-1:0] gain_in,
  input  logic              gain_wr,
  input  logic              sat_clr,
  output logic [DO_W-1:0]   do_re,
  output logic [DO_W-1:0]   do_im,
  output logic              do_vld,
  output logic              do_last,
  output logic [15:0]       sat_cnt
);

  localparam int unsigned CNT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int unsigned P_W   = DI_W + GAIN_W + 1;
  localparam int unsigned Q_W   = P_W + 1;
  localparam int unsigned R_W   = Q_W - GAIN_FRAC;

  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(SYM_LEN - 1);
  localparam logic [GAIN_W-1:0]     GAIN_RST = GAIN_W'(DEFAULT_GAIN);
  localparam logic signed [Q_W-1:0] RND      = Q_W'(1 << (GAIN_FRAC - 1));
  localparam logic signed [R_W-1:0] SAT_HI   = R_W'((1 << (DO_W - 1)) - 1);
  localparam logic signed [R_W-1:0] SAT_LO   = -SAT_HI;

  // Symbol position and gain bookkeeping
  logic [CNT_W-1:0]  cnt;
  logic [GAIN_W-1:0] gain_act;
  logic [GAIN_W-1:0] gain_pend;
  logic              pend_flag;
  logic              sym_start;
  logic [GAIN_W-1:0] gain_sel;

  // Pipeline registers
  logic                    s1_vld, s1_last;
  logic [DI_W-1:0]         s1_re, s1_im;
  logic [GAIN_W-1:0]       s1_gain;
  logic                    s2_vld, s2_last;
  logic signed [P_W-1:0]   s2_p_re, s2_p_im;
  logic                    s3_vld, s3_last;
  logic signed [R_W-1:0]   s3_r_re, s3_r_im;
  logic                    do_clip;

  // Combinational stage results
  logic signed [P_W-1:0]   prod_re, prod_im;
  logic signed [Q_W-1:0]   sum_re, sum_im;
  logic signed [Q_W-1:0]   sh_re, sh_im;
  logic [DO_W:0]           sat_re, sat_im;

  // A pending gain is picked up by the first sample of a symbol
  assign sym_start = di_vld && (cnt == '0);
  assign gain_sel  = (sym_start && pend_flag) ? gain_pend : gain_act;

  // Returns {clip, value} with the value clamped to the symmetric output range
  function automatic logic [DO_W:0] saturate(input logic signed [R_W-1:0] r);
    if (r > SAT_HI)      return {1'b1, DO_W'(SAT_HI)};
    else if (r < SAT_LO) return {1'b1, DO_W'(SAT_LO)};
    else                 return {1'b0, DO_W'(r)};
  endfunction

  // Sample counter and boundary-aligned gain update; a write beats a same-cycle apply
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      gain_act  <= GAIN_RST;
      gain_pend <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (di_vld) cnt <= (cnt == LAST_IDX) ? '0 : cnt + CNT_W'(1);
      if (sym_start && pend_flag) begin
        gain_act  <= gain_pend;
        pend_flag <= 1'b0;
      end
      if (gain_wr) begin
        gain_pend <= gain_in;
        pend_flag <= 1'b1;
      end
    end
  end

  // Signed product with the gain zero-extended to stay positive
  always_comb begin
    prod_re = P_W'($signed(s1_re)) * P_W'($signed({1'b0, s1_gain}));
    prod_im = P_W'($signed(s1_im)) * P_W'($signed({1'b0, s1_gain}));
  end

  // Round half-up, one guard bit so the bias add cannot overflow
  always_comb begin
    sum_re = Q_W'(s2_p_re) + RND;
    sum_im = Q_W'(s2_p_im) + RND;
    sh_re  = sum_re >>> GAIN_FRAC;
    sh_im  = sum_im >>> GAIN_FRAC;
  end

  // Symmetric clamp of the rounded values
  always_comb begin
    sat_re = saturate(s3_r_re);
    sat_im = saturate(s3_r_im);
  end

  // S1..S4 pipeline; outputs are zeroed whenever not valid
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_re   <= '0;
      s1_im   <= '0;
      s1_gain <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_p_re <= '0;
      s2_p_im <= '0;
      s3_vld  <= 1'b0;
      s3_last <= 1'b0;
      s3_r_re <= '0;
      s3_r_im <= '0;
      do_vld  <= 1'b0;
      do_last <= 1'b0;
      do_re   <= '0;
      do_im   <= '0;
      do_clip <= 1'b0;
    end else begin
      s1_vld  <= di_vld;
      s1_last <= di_vld && (cnt == LAST_IDX);
      s1_re   <= di_re;
      s1_im   <= di_im;
      s1_gain <= gain_sel;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      s2_p_re <= prod_re;
      s2_p_im <= prod_im;
      s3_vld  <= s2_vld;
      s3_last <= s2_last;
      s3_r_re <= R_W'(sh_re);
      s3_r_im <= R_W'(sh_im);
      do_vld  <= s3_vld;
      do_last <= s3_vld && s3_last;
      do_re   <= s3_vld ? sat_re[DO_W-1:0] : '0;
      do_im   <= s3_vld ? sat_im[DO_W-1:0] : '0;
      do_clip <= s3_vld && (sat_re[DO_W] || sat_im[DO_W]);
    end
  end

  // Clip counter: clear wins, holds at full scale
  always_ff @(posedge clk) begin
    if (rst || sat_clr)                   sat_cnt <= '0;
    else if (do_clip && sat_cnt != '1)    sat_cnt <= sat_cnt + 16'd1;
  end

endmodule
